// File: rtl/sixteen_pkg.sv
// -----------------------------------------------------------------------------
// sixteen_pkg
// Shared constants and types for the switch-selectable clock divider.
//   DIV_SEL_W : width of the ratio-select switch
//   CNT_W     : width of the divider counter (max ratio 2^CNT_W)
//   div_sel_e : ratio-select encoding (/2, /4, /8, /16)
// -----------------------------------------------------------------------------
package sixteen_pkg;

    localparam int DIV_SEL_W = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [DIV_SEL_W-1:0] {
        DIV2  = 2'b00,
        DIV4  = 2'b01,
        DIV8  = 2'b10,
        DIV16 = 2'b11
    } div_sel_e;

endpackage

// File: rtl/sixteen_div_counter.sv
// -----------------------------------------------------------------------------
// div_counter
// Free-running wrapping up-counter with a synchronous clear, intended for
// reuse by divider blocks.
// Ports:
//   clk : clock, rising-edge active
//   rst : asynchronous active-high reset, forces the count to 0
//   clr : synchronous clear, loads 0 on the next rising edge
//   cnt : current count value
// -----------------------------------------------------------------------------
module div_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sixteen.sv
// -----------------------------------------------------------------------------
// sixteen
// Switch-selectable clock divider producing a registered 50 %-duty clock.
// Ports:
//   clk   : system clock, rising-edge active
//   rst   : asynchronous active-high reset, clears counter, select and output
//   sw    : ratio select, 00=/2 01=/4 10=/8 11=/16 (synchronous to clk)
//   clk_O : divided clock, flop output
// -----------------------------------------------------------------------------
module sixteen #(
    parameter int CNT_W = sixteen_pkg::CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [sixteen_pkg::DIV_SEL_W-1:0] sw,
    output logic                              clk_O
);

    import sixteen_pkg::*;

    logic [DIV_SEL_W-1:0] sw_q;
    logic [DIV_SEL_W-1:0] sw_d;
    logic                 clk_o_q;
    logic                 clk_o_d;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 sel_change;

    // A select change restarts the counter so the new ratio starts at phase 0.
    assign sel_change = (sw != sw_q);

    div_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (sel_change),
        .cnt (cnt)
    );

    // The output follows the selected bit of the value the counter is about
    // to load, so clk_O and cnt stay in phase on the same edge.
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        sw_d    = sw;
        clk_o_d = 1'b0;
        if (!sel_change) begin
            case (div_sel_e'(sw))
                DIV2:    clk_o_d = cnt_inc[0];
                DIV4:    clk_o_d = cnt_inc[1];
                DIV8:    clk_o_d = cnt_inc[2];
                DIV16:   clk_o_d = cnt_inc[CNT_W-1];
                default: clk_o_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q    <= '0;
            clk_o_q <= 1'b0;
        end else begin
            sw_q    <= sw_d;
            clk_o_q <= clk_o_d;
        end
    end

    assign clk_O = clk_o_q;

endmodule

// File: tb/tb_sixteen.sv
// -----------------------------------------------------------------------------
// tb_sixteen
// Directed testbench for the switch-selectable clock divider. Expected clk_O
// waveforms are hand-written bit patterns, one bit per rising clk edge.
// -----------------------------------------------------------------------------
module tb_sixteen;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       clk_O;

    int n_checks;
    int n_fails;

    sixteen dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .clk_O (clk_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: clk_O=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Steps n rising edges; pattern bit (n-1-i) is the clk_O value required
    // just after edge i, so patterns read left to right in time.
    task automatic run_pattern(input string tag, input int n, input logic [63:0] pat);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_bit($sformatf("%s[%0d]", tag, i), clk_O, pat[n-1-i]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        sw       = 2'b10;

        // Reset held for two edges with a nonzero select: output stays low.
        #1;
        check_bit("rst_init", clk_O, 1'b0);
        run_pattern("rst_hold", 2, 64'b00);

        // /2 straight out of reset (select equals the reset select value).
        sw  = 2'b00;
        rst = 1'b0;
        run_pattern("div2", 8, 64'b10101010);

        // /4: select set during reset, so the first edge is a clearing edge.
        rst = 1'b1;
        sw  = 2'b01;
        @(posedge clk);
        #1;
        check_bit("div4_rst", clk_O, 1'b0);
        rst = 1'b0;
        run_pattern("div4", 9, 64'b0_0110_0110);

        // /8 through a full counter wrap.
        rst = 1'b1;
        sw  = 2'b10;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_pattern("div8", 17, 64'b0_000_1111_0000_1111_0);

        // /16 across the 15 -> 0 wrap, stopping in the middle of a high phase.
        rst = 1'b1;
        sw  = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_pattern("div16", 29, 64'b0_0000000_11111111_00000000_11111);

        // Live switch to /2 while high: one clearing edge, then /2 from phase 0.
        sw = 2'b00;
        run_pattern("live_sw", 5, 64'b0_1010);

        // Asynchronous reset during a high phase drops the output at once.
        run_pattern("pre_async", 1, 64'b1);
        rst = 1'b1;
        #1;
        check_bit("async_rst", clk_O, 1'b0);

        // Select changed while in reset: reset wins, then one clearing edge.
        sw = 2'b11;
        run_pattern("rst_sw_hold", 2, 64'b00);
        rst = 1'b0;
        run_pattern("rst_sw_div16", 9, 64'b0_0000000_1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
